spi0_arbiter: RTL

SPI0_ARBITER -- requirements
Module: spi0_arbiter

---
 rtl/spi0_arbiter_pkg.sv | 28 ++
 rtl/spi0_arbiter_if.sv | 48 ++++
 rtl/spi0_arbiter_timeout.sv | 37 +++
 rtl/spi0_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/spi0_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi0_arbiter_pkg
// Description : Shared types and defaults for the two-requester SPI0 arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi0_arbiter_pkg;

    localparam int c_TIMEOUT_CYCLES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XFER     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_0 = 1'b0,
        OWNER_1 = 1'b1
    } owner_t;

    function automatic logic [1:0] owner_onehot(input owner_t owner);
        return (owner == OWNER_1) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi0_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : spi0_arbiter_if
// Description : Requester, response and SPI-engine handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi0_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_last;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_last;

    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    logic                  eng_cmd_valid;
    logic                  eng_cmd_ready;
    logic [DATA_WIDTH-1:0] eng_cmd_data;
    logic                  eng_rsp_valid;
    logic [DATA_WIDTH-1:0] eng_rsp_data;

    // The arbiter is the slave of the requesters and drives the engine.
    modport slave (
        input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output eng_cmd_valid, eng_cmd_data,
        input  eng_cmd_ready, eng_rsp_valid, eng_rsp_data
    );

    modport master (
        output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  eng_cmd_valid, eng_cmd_data,
        output eng_cmd_ready, eng_rsp_valid, eng_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/spi0_arbiter_timeout.sv
`default_nettype none
// ============================================================================
// Module      : spi0_arbiter_timeout
// Description : Idle-cycle counter; expired flags the last allowed idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module spi0_arbiter_timeout
    import spi0_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT
) (
    input  wire logic io_clock,
    input  wire logic io_sysReset,
    input  wire logic enable,
    input  wire logic clear,
    output logic      expired
);

    localparam int               c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge io_clock or posedge io_sysReset) begin
        if (io_sysReset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/spi0_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi0_arbiter
// Description : Round-robin arbiter sharing one SPI engine between two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module spi0_arbiter
    import spi0_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT,
    parameter int DATA_WIDTH     = 8
) (
    input  wire logic     io_clock,
    input  wire logic     io_sysReset,
    spi0_arbiter_if.slave arb_bus,
    output logic          spi_ss_n,
    output logic [1:0]    grant,
    output logic          timeout_pulse
);

    state_t                r_state;
    owner_t                r_owner;
    owner_t                r_last_owner;
    logic                  r_last;

    owner_t                w_pick;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                  w_in_xfer;
    logic                  w_in_wait;
    logic                  w_handshake;
    logic                  w_cnt_en;
    logic                  w_expired;

    assign w_owner_valid = (r_owner == OWNER_1) ? arb_bus.req1_valid : arb_bus.req0_valid;
    assign w_owner_last  = (r_owner == OWNER_1) ? arb_bus.req1_last  : arb_bus.req0_last;
    assign w_owner_data  = (r_owner == OWNER_1) ? arb_bus.req1_data  : arb_bus.req0_data;
    assign w_in_xfer     = (r_state == ST_XFER);
    assign w_in_wait     = (r_state == ST_WAIT_RSP);

    assign arb_bus.eng_cmd_valid = w_in_xfer && w_owner_valid;
    assign arb_bus.eng_cmd_data  = w_owner_data;
    assign arb_bus.req0_ready    = w_in_xfer && (r_owner == OWNER_0) && arb_bus.eng_cmd_ready;
    assign arb_bus.req1_ready    = w_in_xfer && (r_owner == OWNER_1) && arb_bus.eng_cmd_ready;
    assign w_handshake           = arb_bus.eng_cmd_valid && arb_bus.eng_cmd_ready;

    // Responses are only forwarded while a command is outstanding.
    assign arb_bus.rsp0_valid = w_in_wait && (r_owner == OWNER_0) && arb_bus.eng_rsp_valid;
    assign arb_bus.rsp1_valid = w_in_wait && (r_owner == OWNER_1) && arb_bus.eng_rsp_valid;
    assign arb_bus.rsp0_data  = arb_bus.eng_rsp_data;
    assign arb_bus.rsp1_data  = arb_bus.eng_rsp_data;

    always_comb begin
        w_pick = OWNER_0;
        if (arb_bus.req0_valid && arb_bus.req1_valid) begin
            w_pick = (r_last_owner == OWNER_0) ? OWNER_1 : OWNER_0;
        end else if (arb_bus.req1_valid) begin
            w_pick = OWNER_1;
        end
    end

    assign w_cnt_en = w_in_xfer && !w_owner_valid;

    spi0_arbiter_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .io_clock    (io_clock),
        .io_sysReset (io_sysReset),
        .enable      (w_cnt_en),
        .clear       (!w_cnt_en),
        .expired     (w_expired)
    );

    always_ff @(posedge io_clock or posedge io_sysReset) begin
        if (io_sysReset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWNER_0;
            r_last_owner  <= OWNER_1;
            r_last        <= 1'b0;
            grant         <= 2'b00;
            spi_ss_n      <= 1'b1;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arb_bus.req0_valid || arb_bus.req1_valid) begin
                        r_owner  <= w_pick;
                        grant    <= owner_onehot(w_pick);
                        spi_ss_n <= 1'b0;
                        r_state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_handshake) begin
                        r_last  <= w_owner_last;
                        r_state <= ST_WAIT_RSP;
                    end else if (w_expired) begin
                        grant         <= 2'b00;
                        spi_ss_n      <= 1'b1;
                        timeout_pulse <= 1'b1;
                        r_state       <= ST_RELEASE;
                    end
                end
                ST_WAIT_RSP: begin
                    if (arb_bus.eng_rsp_valid) begin
                        if (r_last) begin
                            grant    <= 2'b00;
                            spi_ss_n <= 1'b1;
                            r_state  <= ST_RELEASE;
                        end else begin
                            r_state  <= ST_XFER;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_last_owner <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
